// File: rtl/m_2x2_pkg.sv
// Shared types and constants for the 2x2 result-unpack path.
// Optional feature macro used by the top: M2X2_RELU_EN (clamps negative elements to zero).
package m_2x2_pkg;

   // Default element width and elements per packed 2x2 result word
   localparam int DEF_ELEM_W = 8;
   localparam int N_ELEM     = 4;

   // Unpack FSM states
   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Element index within a word: bit1 = row, bit0 = col
   typedef logic [1:0] elem_idx_t;

   // Packed word at the default element width, [0][0] in the MSBs
   typedef logic [N_ELEM*DEF_ELEM_W-1:0] word_t;

endpackage

// File: rtl/m_2x2_word_fifo.sv
// Small synchronous FIFO holding packed result words ahead of the active word.
// Head entry is visible combinationally on pop_data so the consumer can load it
// on the same edge it pops. Full/empty derive only from pointer flops.
module m_2x2_word_fifo
   import m_2x2_pkg::*;
#(
   parameter int W     = N_ELEM*DEF_ELEM_W,
   parameter int DEPTH = 2
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         push_ok;
   logic         pop_ok;

   // Guard against overflow/underflow even if a caller misbehaves
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointer advance; the extra MSB distinguishes full from empty
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/m_2x2_res_unpack.sv
// Unpacks 2x2 result words into a one-element-per-cycle tagged stream.
// Words queue in m_2x2_word_fifo; one active word is shifted out MSB-first.
// Optional feature: define M2X2_RELU_EN to clamp negative elements to zero at
// the output mux (no added latency).
module m_2x2_res_unpack
   import m_2x2_pkg::*;
#(
   parameter int ELEM_W     = DEF_ELEM_W,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_ELEM*ELEM_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ELEM_W-1:0]        out_data,
   output logic                     out_row,
   output logic                     out_col,
   output logic                     out_last,
   output logic                     busy,
   output logic [CNT_W-1:0]         word_cnt
);

   localparam int WORD_W = N_ELEM*ELEM_W;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              push_fire;
   logic [WORD_W-1:0] fifo_head;
   logic [ELEM_W-1:0] raw_elem;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] active_q, active_d;
   elem_idx_t         e_q, e_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

   // in_ready depends only on FIFO pointer flops, never on out_ready
   assign in_ready  = !fifo_full;
   assign push_fire = in_valid && in_ready;

   m_2x2_word_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_fire),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state: load head word from IDLE, shift per element, chain words without a bubble
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      e_d        = e_q;
      word_cnt_d = word_cnt_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               active_d = fifo_head;
               e_d      = '0;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (e_q != 2'd3) begin
                  active_d = active_q << ELEM_W;
                  e_d      = e_q + 2'd1;
               end else begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     active_d = fifo_head;
                     e_d      = '0;
                  end else begin
                     // Clear so idle outputs read zero
                     active_d = '0;
                     e_d      = '0;
                     state_d  = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, active shift register, element index and drained-word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         active_q   <= '0;
         e_q        <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         active_q   <= active_d;
         e_q        <= e_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // Current element is always the top slice of the shifted active word
   assign raw_elem = active_q[WORD_W-1 -: ELEM_W];

`ifdef M2X2_RELU_EN
   // Two's-complement negative elements clamp to zero
   assign out_data = raw_elem[ELEM_W-1] ? '0 : raw_elem;
`else
   assign out_data = raw_elem;
`endif

   assign out_valid = (state_q == STREAM);
   assign out_row   = e_q[1];
   assign out_col   = e_q[0];
   assign out_last  = (state_q == STREAM) && (e_q == 2'd3);
   assign busy      = !fifo_empty || (state_q == STREAM);
   assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_m_2x2_res_unpack.sv
// Directed bench for m_2x2_res_unpack: latency, streaming, backpressure,
// full FIFO, async reset mid-word and the optional ReLU clamp (M2X2_RELU_EN).
`timescale 1ns/1ps
module tb_m_2x2_res_unpack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_row;
   logic        out_col;
   logic        out_last;
   logic        busy;
   logic [15:0] word_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

`ifdef M2X2_RELU_EN
   localparam logic [31:0] RELU_EXP = 32'h0000_7F01;
`else
   localparam logic [31:0] RELU_EXP = 32'h80FF_7F01;
`endif
   localparam logic [31:0] RST_VEC = 32'h2000_0000;

   logic [31:0] status_vec;
   assign status_vec = {2'b00, in_ready, out_valid, out_data, out_row, out_col,
                        out_last, busy, word_cnt};

   m_2x2_res_unpack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy),
      .word_cnt  (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: run did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      $display("[TB] pushed word %h", w);
   endtask

   task automatic expect_elem(input string tag, input logic [7:0] d, input logic [1:0] idx);
      @(negedge clk);
      check(tag, 32'({out_valid, out_data, out_row, out_col, out_last}),
            32'({1'b1, d, idx[1], idx[0], (idx == 2'd3)}));
   endtask

   // Expects all four elements of w with out_ready held high
   task automatic drain_word(input string tag, input logic [31:0] w);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         b = w[31-8*i -: 8];
         expect_elem($sformatf("%s_e%0d", tag, i), b, 2'(i));
         tick();
      end
      $display("[TB] %s drained word %h", tag, w);
   endtask

   task automatic check_idle(input string tag, input logic [15:0] cnt);
      @(negedge clk);
      check(tag, 32'({out_valid, busy, word_cnt}), 32'({1'b0, 1'b0, cnt}));
      tick();
   endtask

   logic [31:0] full_words [4];

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      full_words[0] = 32'hA1A2_A3A4;
      full_words[1] = 32'hB1B2_B3B4;
      full_words[2] = 32'hC1C2_C3C4;
      full_words[3] = 32'hD1D2_D3D4;

      // Reset values, during and after reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hold", status_vec, RST_VEC);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("rst_vals", status_vec, RST_VEC);
      tick();

      // Single word, 2-cycle latency
      out_ready = 1'b1;
      push_one(32'h0102_0304);
      @(negedge clk);
      check("t1_lat", 32'({out_valid, busy}), 32'h1);
      tick();
      drain_word("t1", 32'h0102_0304);
      check_idle("t1_idle", 16'd1);

      // Back-to-back words, no bubble between them
      in_valid = 1'b1;
      in_data  = 32'h1122_3344;
      tick();
      in_data  = 32'h5566_7788;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      drain_word("t2a", 32'h1122_3344);
      drain_word("t2b", 32'h5566_7788);
      check_idle("t2_idle", 16'd3);

      // Backpressure holds element 22
      push_one(32'h1122_3344);
      @(negedge clk);
      check("t3_lat", 32'(out_valid), 32'h0);
      tick();
      expect_elem("t3_11", 8'h11, 2'd0);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         expect_elem($sformatf("t3_hold%0d", k), 8'h22, 2'd1);
         tick();
      end
      out_ready = 1'b1;
      expect_elem("t3_22", 8'h22, 2'd1);
      tick();
      expect_elem("t3_33", 8'h33, 2'd2);
      tick();
      expect_elem("t3_44", 8'h44, 2'd3);
      tick();
      check_idle("t3_idle", 16'd4);

      // Full: offer 4 words with no drain, only 3 accepted
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = full_words[k];
         @(negedge clk);
         check($sformatf("t4_rdy%0d", k), 32'(in_ready), (k < 3) ? 32'h1 : 32'h0);
         tick();
      end
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_elem($sformatf("t4_a%0d", i), full_words[0][31-8*i -: 8], 2'(i));
         check($sformatf("t4_nrdy%0d", i), 32'(in_ready), 32'h0);
         tick();
      end
      check("t4_rise", 32'(in_ready), 32'h1);
      drain_word("t4b", full_words[1]);
      drain_word("t4c", full_words[2]);
      check_idle("t4_idle", 16'd7);

      // Asynchronous reset mid-word
      push_one(32'hAABB_CCDD);
      @(negedge clk);
      tick();
      expect_elem("t5_aa", 8'hAA, 2'd0);
      tick();
      expect_elem("t5_bb", 8'hBB, 2'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async", status_vec, RST_VEC);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push_one(32'h0102_0304);
      @(negedge clk);
      check("t5_lat", 32'(out_valid), 32'h0);
      tick();
      drain_word("t5", 32'h0102_0304);
      check_idle("t5_idle", 16'd1);

      // Signed elements: clamp when ReLU is compiled in, raw otherwise
      push_one(32'h80FF_7F01);
      @(negedge clk);
      tick();
      drain_word("t6", RELU_EXP);
      check_idle("t6_idle", 16'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
